// File: rtl/mod_up_down_counter.sv
// mod_up_down_counter: N-bit up/down counter over 0..limit with wrap/saturate, load and cascade carry
//   clock      rising-edge clock
//   reset_b    asynchronous active-low reset, q=0
//   enable_b   active-low count enable
//   carry_in_b active-low cascade input, tie low when unused
//   up         1 = count up, 0 = count down
//   sat        1 = saturate at bounds, 0 = wrap
//   set_b      active-low synchronous load of min(set, limit)
//   set        load value
//   limit      terminal value, range is 0..limit
//   carry_b    active-low terminal-count / cascade output, combinational
//   q          current count, registered
// Optional macro UDC_WRAP_FLAG_EN adds flag_clr_b (sync active-low clear) and wrapped (sticky wrap flag).
module mod_up_down_counter #(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset_b,
   input  logic         enable_b,
   input  logic         carry_in_b,
   input  logic         up,
   input  logic         sat,
   input  logic         set_b,
   input  logic [N-1:0] set,
   input  logic [N-1:0] limit,
`ifdef UDC_WRAP_FLAG_EN
   input  logic         flag_clr_b,
   output logic         wrapped,
`endif
   output logic         carry_b,
   output logic [N-1:0] q
);
   logic [N-1:0] count_q, count_d, up_nxt, dn_nxt;
   logic         cnt_en, at_top, at_zero, above, term;
   always_comb begin
      cnt_en  = ~enable_b & ~carry_in_b;
      at_top  = count_q == limit;
      at_zero = count_q == '0;
      above   = count_q > limit;
      term    = up ? at_top : at_zero;
      carry_b = ~(cnt_en & term);
      // an out-of-range count (limit lowered on the fly) snaps back into range regardless of sat
      up_nxt  = above ? '0 : at_top ? (sat ? count_q : '0) : count_q + 1'b1;
      dn_nxt  = above ? limit : at_zero ? (sat ? count_q : limit) : count_q - 1'b1;
      count_d = ~set_b ? ((set > limit) ? limit : set) : cnt_en ? (up ? up_nxt : dn_nxt) : count_q;
   end
   always_ff @(posedge clock or negedge reset_b)
      if (!reset_b) count_q <= '0;
      else          count_q <= count_d;
   assign q = count_q;
`ifdef UDC_WRAP_FLAG_EN
   logic wrapped_q, wrapped_d;
   // a load takes priority over counting, so no wrap happens on a load edge
   always_comb wrapped_d = (set_b & cnt_en & term & ~sat) | (wrapped_q & flag_clr_b);
   always_ff @(posedge clock or negedge reset_b)
      if (!reset_b) wrapped_q <= 1'b0;
      else          wrapped_q <= wrapped_d;
   assign wrapped = wrapped_q;
`endif
endmodule

// File: tb/tb_mod_up_down_counter.sv
// tb_mod_up_down_counter: directed vector bench for mod_up_down_counter including cascade and async reset
module tb_mod_up_down_counter;
   logic       clock = 1'b0, reset_b = 1'b0;
   logic       enable_b = 1'b1, up = 1'b1, sat = 1'b0, set_b = 1'b1;
   logic [7:0] set = '0, limit = 8'd9, q;
   logic       carry_b;
   logic       c_en_b = 1'b1, lo_cb, hi_cb;
   logic [3:0] lo_q, hi_q;
   int         errors = 0, checks = 0;
`ifdef UDC_WRAP_FLAG_EN
   logic flag_clr_b = 1'b1, wrapped, lo_w, hi_w;
`endif
   always #5 clock = ~clock;
   mod_up_down_counter #(.N(8)) dut (
      .clock(clock), .reset_b(reset_b), .enable_b(enable_b), .carry_in_b(1'b0),
      .up(up), .sat(sat), .set_b(set_b), .set(set), .limit(limit),
`ifdef UDC_WRAP_FLAG_EN
      .flag_clr_b(flag_clr_b), .wrapped(wrapped),
`endif
      .carry_b(carry_b), .q(q));
   mod_up_down_counter #(.N(4)) lo (
      .clock(clock), .reset_b(reset_b), .enable_b(c_en_b), .carry_in_b(1'b0),
      .up(1'b1), .sat(1'b0), .set_b(1'b1), .set(4'd0), .limit(4'hf),
`ifdef UDC_WRAP_FLAG_EN
      .flag_clr_b(1'b1), .wrapped(lo_w),
`endif
      .carry_b(lo_cb), .q(lo_q));
   mod_up_down_counter #(.N(4)) hi (
      .clock(clock), .reset_b(reset_b), .enable_b(c_en_b), .carry_in_b(lo_cb),
      .up(1'b1), .sat(1'b0), .set_b(1'b1), .set(4'd0), .limit(4'hf),
`ifdef UDC_WRAP_FLAG_EN
      .flag_clr_b(1'b1), .wrapped(hi_w),
`endif
      .carry_b(hi_cb), .q(hi_q));
   typedef struct {
      logic       set_b, enable_b, up, sat;
      logic [7:0] set, limit;
      logic       exp_cb;
      logic [7:0] exp_q;
   } vec_t;
   vec_t vecs[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic add(input logic sb, eb, u, s, input logic [7:0] sv, lv, input logic cb, input logic [7:0] eq);
      vecs.push_back('{sb, eb, u, s, sv, lv, cb, eq});
   endtask
   initial begin
      // count up 0..9 then wrap, carry low only at q=9
      for (int i = 0; i < 9; i++) add(1, 0, 1, 0, 0, 9, 1, 8'(i + 1));
      add(1, 0, 1, 0, 0, 9, 0, 0);
      // down with saturate at 0 holds with carry low, then wrap to limit
      add(1, 0, 0, 1, 0, 9, 0, 0);
      add(1, 0, 0, 1, 0, 9, 0, 0);
      add(1, 0, 0, 0, 0, 9, 0, 9);
      add(1, 0, 0, 0, 0, 9, 1, 8);
      // load clamps to limit, then limit lowered below q
      add(0, 1, 1, 0, 250, 200, 1, 200);
      add(1, 0, 1, 0, 0, 100, 1, 0);
      add(0, 1, 1, 0, 250, 200, 1, 200);
      add(1, 0, 0, 0, 0, 100, 1, 100);
      // load wins over a terminal count in the same cycle
      add(0, 0, 1, 0, 5, 100, 0, 5);
      // limit 0 keeps q at 0 and carry follows enable
      add(1, 0, 1, 0, 0, 0, 1, 0);
      add(1, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0, 0, 0, 0, 1, 0);
      // limit all ones behaves as a plain binary counter
      add(0, 1, 1, 0, 254, 255, 1, 254);
      add(1, 0, 1, 0, 0, 255, 1, 255);
      add(1, 0, 1, 0, 0, 255, 0, 0);
      add(1, 0, 0, 1, 0, 255, 0, 0);
      add(1, 1, 1, 0, 0, 9, 1, 0);
      #2;
      chk("reset_q", q, 0);
      chk("reset_cb_disabled", carry_b, 1);
      enable_b = 1'b0; up = 1'b0; #1;
      chk("reset_cb_down_en", carry_b, 0);
      enable_b = 1'b1; up = 1'b1;
      @(negedge clock) reset_b = 1'b1;
      @(posedge clock) #1;
      chk("post_reset_q", q, 0);
`ifdef UDC_WRAP_FLAG_EN
      chk("reset_wrapped", wrapped, 0);
`endif
      // cascade: high nibble advances only on low-nibble wraps
      c_en_b = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clock) #1;
         if (i == 15) begin
            chk("casc15_lo", lo_q, 15);
            chk("casc15_lo_cb", lo_cb, 0);
            chk("casc15_hi", hi_q, 0);
         end
         if (i == 16) chk("casc16", {hi_q, lo_q}, 16);
      end
      c_en_b = 1'b1;
      chk("casc300", {hi_q, lo_q}, 44);
      foreach (vecs[i]) begin
         {set_b, enable_b, up, sat} = {vecs[i].set_b, vecs[i].enable_b, vecs[i].up, vecs[i].sat};
         set = vecs[i].set; limit = vecs[i].limit;
         #1;
         chk($sformatf("vec%0d_carry_b", i), carry_b, vecs[i].exp_cb);
         @(posedge clock) #1;
         chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      end
      // asynchronous reset between edges
      set_b = 1'b0; set = 8'd7; limit = 8'd9; enable_b = 1'b1;
      @(posedge clock) #1;
      chk("load7", q, 7);
      set_b = 1'b0; set = 8'd7;
      set_b = 1'b1; enable_b = 1'b0; up = 1'b1; sat = 1'b0;
      #3 reset_b = 1'b0;
      #1 chk("async_reset_q", q, 0);
      @(posedge clock) #1;
      chk("reset_held_q", q, 0);
      reset_b = 1'b1;
      @(posedge clock) #1;
      chk("resume_q", q, 1);
`ifdef UDC_WRAP_FLAG_EN
      // set wins over clear, then clear alone drops the flag
      enable_b = 1'b1; set_b = 1'b0; set = 8'd9; limit = 8'd9;
      @(posedge clock) #1;
      chk("flag_load_no_set", wrapped, 0);
      set_b = 1'b1; enable_b = 1'b0; up = 1'b1; sat = 1'b0; flag_clr_b = 1'b0;
      @(posedge clock) #1;
      chk("flag_set_wins", wrapped, 1);
      chk("flag_wrap_q", q, 0);
      enable_b = 1'b1;
      @(posedge clock) #1;
      chk("flag_cleared", wrapped, 0);
      flag_clr_b = 1'b1;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
